imem_boot_loader: RTL and testbench
===================================

// Module: imem_boot_loader
// PURPOSE
//  Boot-time program loader between an external byte stream (UART/host bridge) and the core's instruction memory.
//  Packs bytes into 32-bit words and writes them into the instruction-memory write port.
//  Holds data_path in reset through core_rst until the image is fully written, then releases the core.
// PARAMETERS
//  ADDR_W     8    instruction-memory word-address width
//  MAX_WORDS  256  largest legal image in words; must be <= 2**ADDR_W
// PORTS
//  clk          in   1       system clock, rising edge
//  rst_n        in   1       asynchronous active-low reset
//  s_valid      in   1       upstream byte valid
//  s_data       in   8       upstream byte
//  s_ready      out  1       loader can accept a byte
//  imem_we      out  1       instruction-memory write strobe, one cycle per word
//  imem_addr    out  ADDR_W  word address of the write
//  imem_wdata   out  32      word to write
//  core_rst     out  1       active-high reset driven to data_path
//  done         out  1       image loaded; sticky until rst_n
//  error        out  1       bad header or checksum; sticky until rst_n
//  words_loaded out  ADDR_W+1 count of completed words
// BEHAVIOUR
//  Reset values: s_ready=1, imem_we=0, imem_addr=0, imem_wdata=0, core_rst=1, done=0, error=0, words_loaded=0.
//  Transfer: a byte is accepted on each rising edge with s_valid&&s_ready. No combinational path from s_valid to s_ready.
//  Stream format:
//   - 2-byte little-endian word count N, then 4*N payload bytes.
//   - Payload words are little-endian: the first byte goes to wdata[7:0].
//  FSM: HDR_LO -> HDR_HI -> LOAD -> [CHECK] -> DONE; any state -> ERROR on a fault.
//   - HDR_LO: latch N[7:0].
//   - HDR_HI: latch N[15:8]. N==0 or N>MAX_WORDS -> ERROR; otherwise -> LOAD.
//   - LOAD:
//     - A 2-bit byte counter is used; on the 4th byte, imem_we=1 for exactly the next cycle.
//     - imem_addr=word index and imem_wdata=the assembled word, both registered.
//     - words_loaded increments at that same edge.
//   - If the last payload byte is accepted at edge k: imem_we is high during k..k+1; the state is DONE (or CHECK) after edge k.
//   - DONE: s_ready=0, done=1 after edge k, core_rst=0 after edge k+1. The one-cycle gap lets the last write complete first.
//   - ERROR: s_ready=0, error=1, core_rst stays 1, imem_we=0; exits only via rst_n.
//  Counter widths: the word index is ADDR_W+1 bits; writes never exceed MAX_WORDS-1 because N is range-checked.
//  Bytes offered in DONE or ERROR are ignored (s_ready=0).
//  rst_n mid-load: everything returns to reset values immediately and the partial word is discarded. Memory contents already written are not cleared. A fresh header is expected.
// CONFIGURATION
//  LOADER_CHECKSUM_EN defined:
//   - After the payload, the FSM enters CHECK and accepts one byte.
//   - If it equals the XOR of all 4*N payload bytes -> DONE; otherwise -> ERROR.
//   - done and core_rst timing is measured from the checksum byte edge.
//  LOADER_CHECKSUM_EN undefined: no CHECK state; LOAD goes directly to DONE.
// STRUCTURE
//  Shared header riscv_defs: state encodings (LDR_HDR_LO..LDR_ERROR), BOOT_WORD_W=32.
//  Sub-module byte_packer: 8->32 little-endian shift register with a 2-bit counter and word_valid pulse.
//  The top level keeps the FSM, header, address and checksum logic.
// TESTING
//  1. N=2, bytes 02 00 13 01 50 00 93 01 30 00 -> writes addr0=0x00500113, addr1=0x00300193. Then done=1, with core_rst=0 one cycle later, words_loaded=2.
//  2. Same stream with s_valid high only every 3rd cycle -> identical writes. Exactly 2 imem_we pulses, no duplicates.
//  3. Header 00 00 -> error=1, s_ready=0, core_rst=1, no imem_we.
//  4. Header 01 01 (N=257, MAX_WORDS=256) -> error=1 after HDR_HI, no imem_we.
//  5. rst_n low for 2 cycles after 6 bytes of test 1 -> all outputs at reset values. Resending the full stream then gives the test 1 result.
//  6. LOADER_CHECKSUM_EN, N=1 word 0x00000013, checksum 0x13 -> done. With checksum 0x12 -> error=1, core_rst stays 1.

Source files
------------

// File: rtl/imem_boot_loader_pkg.sv
// rtl/imem_boot_loader_pkg.sv - shared loader state encodings, word width and header range check
package imem_boot_loader_pkg;

  localparam int BOOT_WORD_W = 32;

  typedef enum logic [2:0] {
    LDR_HDR_LO,
    LDR_HDR_HI,
    LDR_LOAD,
    LDR_CHECK,
    LDR_DONE,
    LDR_ERROR
  } ldr_state_e;

  // A legal image holds at least one word and no more than max_words.
  function automatic logic hdr_ok(input logic [15:0] n, input int max_words);
    return (n != 16'd0) && (int'(n) <= max_words);
  endfunction

endpackage

// File: rtl/imem_boot_loader_if.sv
// rtl/imem_boot_loader_if.sv - byte-stream input and instruction-memory write port of the boot loader
interface imem_boot_loader_if #(
  parameter int ADDR_W = 8
);
  import imem_boot_loader_pkg::*;

  logic                   s_valid;
  logic [7:0]             s_data;
  logic                   s_ready;
  logic                   imem_we;
  logic [ADDR_W-1:0]      imem_addr;
  logic [BOOT_WORD_W-1:0] imem_wdata;

  modport master (
    input  s_valid, s_data,
    output s_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    output s_valid, s_data,
    input  s_ready, imem_we, imem_addr, imem_wdata
  );

endinterface

// File: rtl/imem_boot_loader_byte_packer.sv
// rtl/imem_boot_loader_byte_packer.sv - 8->32 little-endian packer; word_valid_o marks the 4th byte
module imem_boot_loader_byte_packer
  import imem_boot_loader_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   byte_valid_i,
  input  logic [7:0]             byte_i,
  output logic [BOOT_WORD_W-1:0] word_o,
  output logic                   word_valid_o
);

  logic [1:0]  cnt_q, cnt_d;
  logic [23:0] sr_q, sr_d;

  always_comb begin
    cnt_d = cnt_q;
    sr_d  = sr_q;
    if (byte_valid_i) begin
      cnt_d = cnt_q + 2'd1;
      sr_d  = {byte_i, sr_q[23:8]};
    end
  end

  // The completing byte bypasses the shift register so the word is ready at its own edge.
  assign word_o       = {byte_i, sr_q};
  assign word_valid_o = byte_valid_i && (cnt_q == 2'd3);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= 2'd0;
      sr_q  <= 24'd0;
    end else begin
      cnt_q <= cnt_d;
      sr_q  <= sr_d;
    end
  end

endmodule

// File: rtl/imem_boot_loader.sv
// rtl/imem_boot_loader.sv - boot image loader: header, packing, imem writes, core reset release
// Optional trailing XOR checksum byte enabled by LOADER_CHECKSUM_EN.
module imem_boot_loader
  import imem_boot_loader_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int MAX_WORDS = 256
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  imem_boot_loader_if.master  bus,
  output logic                core_rst_o,
  output logic                done_o,
  output logic                error_o,
  output logic [ADDR_W:0]     words_loaded_o
);

`ifdef LOADER_CHECKSUM_EN
  localparam ldr_state_e LOAD_EXIT = LDR_CHECK;
  logic [7:0] csum_q, csum_d;
`else
  localparam ldr_state_e LOAD_EXIT = LDR_DONE;
`endif

  ldr_state_e             state_q, state_d;
  logic [7:0]             n_lo_q, n_lo_d;
  logic [15:0]            n_q, n_d;
  logic [ADDR_W:0]        words_q, words_d;
  logic                   imem_we_q, imem_we_d;
  logic [ADDR_W-1:0]      imem_addr_q, imem_addr_d;
  logic [BOOT_WORD_W-1:0] imem_wdata_q, imem_wdata_d;
  logic                   core_rst_q;
  logic                   s_ready, accept, byte_valid, word_valid;
  logic [BOOT_WORD_W-1:0] word;

  // s_ready depends only on state, never on s_valid.
  assign s_ready    = (state_q == LDR_HDR_LO) || (state_q == LDR_HDR_HI) ||
                      (state_q == LDR_LOAD)   || (state_q == LDR_CHECK);
  assign accept     = bus.s_valid && s_ready;
  assign byte_valid = accept && (state_q == LDR_LOAD);

  imem_boot_loader_byte_packer u_packer (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .byte_valid_i (byte_valid),
    .byte_i       (bus.s_data),
    .word_o       (word),
    .word_valid_o (word_valid)
  );

  always_comb begin
    state_d      = state_q;
    n_lo_d       = n_lo_q;
    n_d          = n_q;
    words_d      = words_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
`ifdef LOADER_CHECKSUM_EN
    csum_d       = csum_q;
`endif
    if (word_valid) begin
      imem_we_d    = 1'b1;
      imem_addr_d  = words_q[ADDR_W-1:0];
      imem_wdata_d = word;
      words_d      = words_q + 1'b1;
    end
    case (state_q)
      LDR_HDR_LO: begin
        if (accept) begin
          n_lo_d  = bus.s_data;
          state_d = LDR_HDR_HI;
        end
      end
      LDR_HDR_HI: begin
        if (accept) begin
          n_d     = {bus.s_data, n_lo_q};
          state_d = hdr_ok(n_d, MAX_WORDS) ? LDR_LOAD : LDR_ERROR;
        end
      end
      LDR_LOAD: begin
`ifdef LOADER_CHECKSUM_EN
        if (byte_valid) csum_d = csum_q ^ bus.s_data;
`endif
        if (word_valid && (16'(words_d) == n_q)) state_d = LOAD_EXIT;
      end
`ifdef LOADER_CHECKSUM_EN
      LDR_CHECK: begin
        if (accept) state_d = (bus.s_data == csum_q) ? LDR_DONE : LDR_ERROR;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= LDR_HDR_LO;
      n_lo_q       <= 8'd0;
      n_q          <= 16'd0;
      words_q      <= '0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      core_rst_q   <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
      csum_q       <= 8'd0;
`endif
    end else begin
      state_q      <= state_d;
      n_lo_q       <= n_lo_d;
      n_q          <= n_d;
      words_q      <= words_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      // Released one cycle after DONE so the final write lands before the core runs.
      core_rst_q   <= (state_q != LDR_DONE);
`ifdef LOADER_CHECKSUM_EN
      csum_q       <= csum_d;
`endif
    end
  end

  assign bus.s_ready     = s_ready;
  assign bus.imem_we     = imem_we_q;
  assign bus.imem_addr   = imem_addr_q;
  assign bus.imem_wdata  = imem_wdata_q;
  assign core_rst_o      = core_rst_q;
  assign done_o          = (state_q == LDR_DONE);
  assign error_o         = (state_q == LDR_ERROR);
  assign words_loaded_o  = words_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// tb/tb_imem_boot_loader.sv - directed self-checking bench for imem_boot_loader
module tb_imem_boot_loader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       core_rst, done, error;
  logic [8:0] words_loaded;
  int         n_cmp = 0;
  int         n_bad = 0;

  imem_boot_loader_if #(.ADDR_W(8)) bus ();

  imem_boot_loader #(.ADDR_W(8), .MAX_WORDS(256)) dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .bus            (bus),
    .core_rst_o     (core_rst),
    .done_o         (done),
    .error_o        (error),
    .words_loaded_o (words_loaded)
  );

  always #5 clk = ~clk;

  logic [7:0] img [0:9] = '{8'h02, 8'h00, 8'h13, 8'h01, 8'h50, 8'h00, 8'h93, 8'h01, 8'h30, 8'h00};

  int         wr_n = 0;
  logic [7:0] wr_addr [0:63];
  logic [31:0] wr_data [0:63];

  always @(negedge clk) begin
    if (bus.imem_we === 1'b1) begin
      if (wr_n < 64) begin
        wr_addr[wr_n] = bus.imem_addr;
        wr_data[wr_n] = bus.imem_wdata;
      end
      wr_n++;
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t = 0;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    bus.s_valid = 1'b1;
    bus.s_data  = b;
    while (bus.s_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout: s_ready=%b after %0d cycles, required 1", bus.s_ready, t);
      bus.s_valid = 1'b0;
    end else begin
      @(posedge clk); #1;
      bus.s_valid = 1'b0;
    end
  endtask

  task automatic offer_ignored(input int cycles);
    @(negedge clk);
    bus.s_valid = 1'b1;
    bus.s_data  = 8'hAA;
    repeat (cycles) @(negedge clk);
    bus.s_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.s_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_cmp++; if (bus.s_ready !== 1'b1) begin n_bad++; $display("FAIL rst_s_ready: got %b want 1", bus.s_ready); end
    n_cmp++; if (bus.imem_we !== 1'b0) begin n_bad++; $display("FAIL rst_imem_we: got %b want 0", bus.imem_we); end
    n_cmp++; if (bus.imem_addr !== 8'h00) begin n_bad++; $display("FAIL rst_imem_addr: got %h want 00", bus.imem_addr); end
    n_cmp++; if (bus.imem_wdata !== 32'h0) begin n_bad++; $display("FAIL rst_imem_wdata: got %h want 0", bus.imem_wdata); end
    n_cmp++; if (core_rst !== 1'b1) begin n_bad++; $display("FAIL rst_core_rst: got %b want 1", core_rst); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL rst_done: got %b want 0", done); end
    n_cmp++; if (error !== 1'b0) begin n_bad++; $display("FAIL rst_error: got %b want 0", error); end
    n_cmp++; if (words_loaded !== 9'd0) begin n_bad++; $display("FAIL rst_words: got %0d want 0", words_loaded); end
    rst_n = 1'b1;
  endtask

  // Sends the two-word image and checks writes, done/core_rst timing and DONE-state behaviour.
  task automatic test_basic(input int gap, input string nm);
    int base = wr_n;
    for (int i = 0; i < 10; i++) send_byte(img[i], gap);
`ifdef LOADER_CHECKSUM_EN
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL %s_done_before_csum: got %b want 0", nm, done); end
    send_byte(8'hE0, gap);
`else
    n_cmp++; if (bus.imem_we !== 1'b1) begin n_bad++; $display("FAIL %s_last_we: got %b want 1", nm, bus.imem_we); end
`endif
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL %s_done: got %b want 1", nm, done); end
    n_cmp++; if (core_rst !== 1'b1) begin n_bad++; $display("FAIL %s_core_rst_k: got %b want 1", nm, core_rst); end
    @(posedge clk); #1;
    n_cmp++; if (core_rst !== 1'b0) begin n_bad++; $display("FAIL %s_core_rst_k1: got %b want 0", nm, core_rst); end
    n_cmp++; if (bus.imem_we !== 1'b0) begin n_bad++; $display("FAIL %s_we_k1: got %b want 0", nm, bus.imem_we); end
    n_cmp++; if (bus.s_ready !== 1'b0) begin n_bad++; $display("FAIL %s_s_ready: got %b want 0", nm, bus.s_ready); end
    offer_ignored(3);
    @(posedge clk); #1;
    n_cmp++; if (wr_n - base !== 2) begin n_bad++; $display("FAIL %s_write_count: got %0d want 2", nm, wr_n - base); end
    n_cmp++; if (words_loaded !== 9'd2) begin n_bad++; $display("FAIL %s_words: got %0d want 2", nm, words_loaded); end
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL %s_done_sticky: got %b want 1", nm, done); end
    if (wr_n - base >= 2) begin
      n_cmp++; if (wr_addr[base] !== 8'd0) begin n_bad++; $display("FAIL %s_addr0: got %h want 00", nm, wr_addr[base]); end
      n_cmp++; if (wr_data[base] !== 32'h00500113) begin n_bad++; $display("FAIL %s_data0: got %h want 00500113", nm, wr_data[base]); end
      n_cmp++; if (wr_addr[base+1] !== 8'd1) begin n_bad++; $display("FAIL %s_addr1: got %h want 01", nm, wr_addr[base+1]); end
      n_cmp++; if (wr_data[base+1] !== 32'h00300193) begin n_bad++; $display("FAIL %s_data1: got %h want 00300193", nm, wr_data[base+1]); end
    end
  endtask

  task automatic test_bad_header(input logic [7:0] lo, input logic [7:0] hi, input string nm);
    int base;
    do_reset();
    base = wr_n;
    send_byte(lo, 0);
    send_byte(hi, 0);
    n_cmp++; if (error !== 1'b1) begin n_bad++; $display("FAIL %s_error: got %b want 1", nm, error); end
    n_cmp++; if (bus.s_ready !== 1'b0) begin n_bad++; $display("FAIL %s_s_ready: got %b want 0", nm, bus.s_ready); end
    offer_ignored(4);
    @(posedge clk); #1;
    n_cmp++; if (core_rst !== 1'b1) begin n_bad++; $display("FAIL %s_core_rst: got %b want 1", nm, core_rst); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL %s_done: got %b want 0", nm, done); end
    n_cmp++; if (error !== 1'b1) begin n_bad++; $display("FAIL %s_error_sticky: got %b want 1", nm, error); end
    n_cmp++; if (wr_n !== base) begin n_bad++; $display("FAIL %s_no_write: got %0d writes want 0", nm, wr_n - base); end
  endtask

  task automatic test_max_header();
    do_reset();
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    n_cmp++; if (error !== 1'b0) begin n_bad++; $display("FAIL max_hdr_error: got %b want 0", error); end
    n_cmp++; if (bus.s_ready !== 1'b1) begin n_bad++; $display("FAIL max_hdr_s_ready: got %b want 1", bus.s_ready); end
  endtask

  task automatic test_midload_reset();
    do_reset();
    for (int i = 0; i < 6; i++) send_byte(img[i], 0);
    n_cmp++; if (bus.imem_we !== 1'b1) begin n_bad++; $display("FAIL mid_we_before: got %b want 1", bus.imem_we); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.imem_we !== 1'b0) begin n_bad++; $display("FAIL mid_imem_we: got %b want 0", bus.imem_we); end
    n_cmp++; if (bus.imem_wdata !== 32'h0) begin n_bad++; $display("FAIL mid_wdata: got %h want 0", bus.imem_wdata); end
    n_cmp++; if (bus.imem_addr !== 8'h0) begin n_bad++; $display("FAIL mid_addr: got %h want 00", bus.imem_addr); end
    n_cmp++; if (words_loaded !== 9'd0) begin n_bad++; $display("FAIL mid_words: got %0d want 0", words_loaded); end
    n_cmp++; if (bus.s_ready !== 1'b1) begin n_bad++; $display("FAIL mid_s_ready: got %b want 1", bus.s_ready); end
    n_cmp++; if (core_rst !== 1'b1) begin n_bad++; $display("FAIL mid_core_rst: got %b want 1", core_rst); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    test_basic(0, "resend");
  endtask

  task automatic test_single_word();
    int base;
    do_reset();
    base = wr_n;
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'h13, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h13, 0);
`endif
    @(posedge clk); #1;
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL one_done: got %b want 1", done); end
    n_cmp++; if (core_rst !== 1'b0) begin n_bad++; $display("FAIL one_core_rst: got %b want 0", core_rst); end
    n_cmp++; if (wr_n - base !== 1) begin n_bad++; $display("FAIL one_count: got %0d want 1", wr_n - base); end
    if (wr_n - base == 1) begin
      n_cmp++; if (wr_data[base] !== 32'h00000013) begin n_bad++; $display("FAIL one_data: got %h want 00000013", wr_data[base]); end
    end
`ifdef LOADER_CHECKSUM_EN
    do_reset();
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'h13, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h12, 0);
    repeat (2) @(posedge clk); #1;
    n_cmp++; if (error !== 1'b1) begin n_bad++; $display("FAIL csum_bad_error: got %b want 1", error); end
    n_cmp++; if (core_rst !== 1'b1) begin n_bad++; $display("FAIL csum_bad_core_rst: got %b want 1", core_rst); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL csum_bad_done: got %b want 0", done); end
`endif
  endtask

  initial begin
    bus.s_valid = 1'b0;
    bus.s_data  = 8'h00;
    test_reset();
    test_basic(0, "basic");
    do_reset();
    test_basic(2, "throttle");
    test_bad_header(8'h00, 8'h00, "n_zero");
    test_bad_header(8'h01, 8'h01, "n_257");
    test_max_header();
    test_midload_reset();
    test_single_word();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1);
  end

endmodule
